dma_burst_streamer: RTL
=======================

// Module: dma_burst_streamer
// PURPOSE
// Parametrised successor of the single-direction DMA streamer. Splits one descriptor (addr, bytes, mode) into AXI
// burst requests for the read or write channel. Adds multi-beat unaligned bursts (separate first/last-beat strobes),
// generic DATA_WIDTH, and an outstanding-transaction credit limit. Sits between the DMA FSM and the AXI master I/F.
// PARAMETERS
// STREAM_TYPE      0     0 = read (src addr/rd_mode), 1 = write (dst addr/wr_mode); selects the status tag only
// ADDR_WIDTH       32    address width
// DATA_WIDTH       64    bus width, power of two, 32..512; BPB = DATA_WIDTH/8 bytes per beat
// BYTES_WIDTH      32    descriptor byte-count width
// MAX_BEATS        256   hard cap on beats per burst (1..256)
// MAX_OUTSTANDING  4     max issued but uncompleted bursts (>=1)
// PORTS
// clk              in   1           clock
// rst              in   1           synchronous, active-low reset
// desc_valid_i     in   1           descriptor offered
// desc_ready_o     out  1           descriptor accepted (high only in IDLE)
// desc_addr_i      in   ADDR_WIDTH  start byte address
// desc_bytes_i     in   BYTES_WIDTH byte count
// desc_fixed_i     in   1           1 = FIXED burst, 0 = INCR
// max_beats_i      in   8           CSR cap: beats <= max_beats_i+1
// abort_i          in   1           stop issuing; level-sensitive
// req_valid_o      out  1           burst request valid
// req_ready_i      in   1           AXI I/F accepts request
// req_addr_o       out  ADDR_WIDTH  beat-aligned burst address
// req_alen_o       out  8           beats-1
// req_size_o       out  3           $clog2(BPB)
// req_fixed_o      out  1           burst mode
// req_strb_first_o out  BPB         strobe, first beat
// req_strb_last_o  out  BPB         strobe, last beat (== first when alen==0)
// txn_done_i       in   1           one burst completed (RLAST / BRESP)
// busy_o           out  1           state != IDLE
// done_o           out  1           1-cycle pulse on return to IDLE
// aborted_o        out  1           valid with done_o; descriptor was aborted
// BEHAVIOUR
// - Reset: state IDLE, all req_*/done/aborted/busy = 0, outstanding = 0, remaining = 0. desc_ready_o = 1 the cycle after release.
// - FSM: IDLE -> ISSUE on desc_valid_i && bytes != 0 (latch addr/bytes/mode). bytes == 0: done_o next cycle, stay IDLE.
//   ISSUE -> DRAIN on the handshake that makes remaining 0, or on abort. DRAIN -> IDLE when outstanding == 0; done_o pulses.
// - Requests are registered. First req_valid_o appears 1 cycle after acceptance. On handshake the next request loads the
//   same cycle (back-to-back, no bubble). While req_valid_o && !req_ready_i, every req_* output holds stable.
// - Burst calc, INCR: off = addr % BPB. beats = min(ceil((off+rem)/BPB), MAX_BEATS, max_beats_i+1, (4096-addr[11:0]+off)/BPB).
//   consumed = min(rem, beats*BPB-off). strb_first = ones<<off. strb_last = ones >> (BPB-1-((off+consumed-1)%BPB)).
//   If beats == 1, both strobes = their AND. addr += consumed.
// - Burst calc, FIXED: addr is constant and there is no 4KB check. Aligned with rem >= BPB: beats = min(floor(rem/BPB), 16, caps),
//   strobes all ones. Otherwise a single beat with the partial strobe as in INCR.
// - Outstanding: +1 on handshake, -1 on txn_done_i; both in one cycle = unchanged. req_valid_o is not asserted while count == MAX_OUTSTANDING.
//   txn_done_i at count 0 is ignored (the bench flags it as an error).
// - Abort in ISSUE: a pending unaccepted request completes its handshake (AXI valid is never dropped). Then DRAIN. aborted_o = 1 with done_o.
//   abort_i in IDLE or DRAIN has no effect beyond setting aborted_o in DRAIN.
// - Arithmetic: remaining is BYTES_WIDTH unsigned and never underflows (consumed <= rem). Address wrap at 2^ADDR_WIDTH is not supported;
//   the 4KB cap forbids crossing a page.
// - Reset mid-operation: immediate return to reset values; in-flight bursts are forgotten.
// STRUCTURE
// - dma_utils_pkg: dma_bstr_st_t {IDLE, ISSUE, DRAIN}; s_dma_burst_req_t {addr, alen, size, fixed, strb_first, strb_last}.
// - Sub-module dma_burst_calc (combinational): addr/rem/mode/caps -> s_dma_burst_req_t + consumed. Unit-tested standalone.
// TESTING (DATA_WIDTH=64, MAX_BEATS=256, max_beats_i=255)
// - INCR 0x1000, 0x200 B -> one req addr 0x1000 alen 63, strb FF/FF; done_o 1 cycle after txn_done_i.
// - INCR 0x0FFD, 20 B -> req addr 0x0FF8 alen 0 strb E0/E0; then addr 0x1000 alen 2 strb FF/01; then done.
// - FIXED 0x2000, 256 B -> two reqs addr 0x2000 alen 15 strb FF/FF; FIXED 0x2003, 5 B -> one req alen 0 strb F8.
// - MAX_OUTSTANDING=2, txn_done_i low -> two handshakes, then req_valid_o low; one txn_done_i pulse -> third req issued next cycle.
// - Abort with req_valid_o=1, req_ready_i=0 for 3 cycles -> req held stable, accepted, no further reqs; done_o+aborted_o after drain.
// - rst low mid-ISSUE with 2 outstanding -> next cycle req_valid_o=0, busy_o=0; after release desc_ready_o=1 and a new descriptor runs cleanly.

Source files
------------

// File: rtl/dma_utils_pkg.sv
// dma_utils_pkg: shared types for the DMA burst streamer and its burst calculator
package dma_utils_pkg;
  localparam int MAX_AW = 64;
  localparam int MAX_BPB = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} dma_bstr_st_t;
  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic [7:0] alen;
    logic [2:0] size;
    logic fixed;
    logic [MAX_BPB-1:0] strb_first;
    logic [MAX_BPB-1:0] strb_last;
  } s_dma_burst_req_t;
endpackage

// File: rtl/dma_burst_streamer_if.sv
// dma_burst_streamer_if: descriptor, burst-request and status signals of the burst streamer
interface dma_burst_streamer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BYTES_WIDTH = 32
);
  localparam int BPB = DATA_WIDTH / 8;
  logic desc_valid_i;
  logic desc_ready_o;
  logic [ADDR_WIDTH-1:0] desc_addr_i;
  logic [BYTES_WIDTH-1:0] desc_bytes_i;
  logic desc_fixed_i;
  logic [7:0] max_beats_i;
  logic abort_i;
  logic req_valid_o;
  logic req_ready_i;
  logic [ADDR_WIDTH-1:0] req_addr_o;
  logic [7:0] req_alen_o;
  logic [2:0] req_size_o;
  logic req_fixed_o;
  logic [BPB-1:0] req_strb_first_o;
  logic [BPB-1:0] req_strb_last_o;
  logic txn_done_i;
  logic busy_o;
  logic done_o;
  logic aborted_o;
  modport master (
    input desc_valid_i, desc_addr_i, desc_bytes_i, desc_fixed_i, max_beats_i, abort_i, req_ready_i, txn_done_i,
    output desc_ready_o, req_valid_o, req_addr_o, req_alen_o, req_size_o, req_fixed_o, req_strb_first_o,
    req_strb_last_o, busy_o, done_o, aborted_o
  );
  modport slave (
    output desc_valid_i, desc_addr_i, desc_bytes_i, desc_fixed_i, max_beats_i, abort_i, req_ready_i, txn_done_i,
    input desc_ready_o, req_valid_o, req_addr_o, req_alen_o, req_size_o, req_fixed_o, req_strb_first_o,
    req_strb_last_o, busy_o, done_o, aborted_o
  );
endinterface

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: sizes the next burst (beats, strobes, bytes consumed) from address, remaining bytes and caps
module dma_burst_calc
  import dma_utils_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BYTES_WIDTH = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [BYTES_WIDTH-1:0] rem,
  input  logic                   fixed,
  input  logic [7:0]             max_beats,
  output s_dma_burst_req_t       req,
  output logic [BYTES_WIDTH-1:0] consumed
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int LB = $clog2(BPB);
  localparam int W = (BYTES_WIDTH > 14 ? BYTES_WIDTH : 14) + 2;
  localparam logic [BPB-1:0] ONES = '1;
  logic [LB-1:0] off, last_idx;
  logic [W-1:0] need, page, cap, beats, span, take;
  logic [BPB-1:0] sf, sl;
  function automatic logic [W-1:0] mn(input logic [W-1:0] a, input logic [W-1:0] b);
    return a < b ? a : b;
  endfunction
  always_comb begin
    off = addr[LB-1:0];
    need = (W'(off) + W'(rem) + W'(BPB - 1)) >> LB;
    page = W'(4096 >> LB) - W'(addr[11:LB]);
    cap = mn(W'(MAX_BEATS), W'(max_beats) + W'(1));
    beats = !fixed ? mn(mn(need, cap), page) :
            (off == '0 && W'(rem) >= W'(BPB)) ? mn(mn(W'(rem) >> LB, W'(16)), cap) : W'(1);
    span = (beats << LB) - W'(off);
    take = mn(W'(rem), span);
    consumed = take[BYTES_WIDTH-1:0];
    last_idx = LB'(W'(off) + take - W'(1));
    sf = ONES << off;
    sl = ONES >> (LB'(BPB - 1) - last_idx);
    req = '0;
    req.addr = MAX_AW'({addr[ADDR_WIDTH-1:LB], LB'(0)});
    req.alen = 8'(beats - W'(1));
    req.size = 3'(LB);
    req.fixed = fixed;
    req.strb_first = MAX_BPB'(beats == W'(1) ? sf & sl : sf);
    req.strb_last = MAX_BPB'(beats == W'(1) ? sf & sl : sl);
  end
endmodule

// File: rtl/dma_burst_streamer.sv
// dma_burst_streamer: splits one DMA descriptor into AXI burst requests under an outstanding-burst credit limit
module dma_burst_streamer
  import dma_utils_pkg::*;
#(
  parameter int STREAM_TYPE = 0,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BYTES_WIDTH = 32,
  parameter int MAX_BEATS = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst,
  dma_burst_streamer_if.master bus
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  dma_bstr_st_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, c_addr;
  logic [BYTES_WIDTH-1:0] rem_q, c_rem, consumed;
  logic fixed_q, c_fixed, abort_q, req_valid, done_q, aborted_q;
  logic [CW-1:0] cnt, cnt_nx;
  logic hs, free, accept, load, done_nx, aborted_nx;
  s_dma_burst_req_t calc_req, req_q;
  logic unused;
  if (STREAM_TYPE < 0 || STREAM_TYPE > 1) begin : g_bad_stream_type
    $error("STREAM_TYPE must be 0 or 1");
  end
  dma_burst_calc #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BYTES_WIDTH(BYTES_WIDTH), .MAX_BEATS(MAX_BEATS)
  ) u_calc (
    .addr(c_addr), .rem(c_rem), .fixed(c_fixed), .max_beats(bus.max_beats_i), .req(calc_req), .consumed(consumed)
  );
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nx;
  // The first burst is sized straight from the descriptor so it is valid one cycle after acceptance
  always_comb begin
    hs = req_valid && bus.req_ready_i;
    free = !req_valid || hs;
    cnt_nx = cnt + CW'(hs) - CW'(bus.txn_done_i && cnt != '0);
    accept = state == IDLE && bus.desc_valid_i;
    c_addr = state == IDLE ? bus.desc_addr_i : addr_q;
    c_rem = state == IDLE ? bus.desc_bytes_i : rem_q;
    c_fixed = state == IDLE ? bus.desc_fixed_i : fixed_q;
    load = (accept && bus.desc_bytes_i != '0) ||
           (state == ISSUE && free && !bus.abort_i && rem_q != '0 && cnt_nx < CW'(MAX_OUTSTANDING));
    state_nx = state;
    done_nx = accept && bus.desc_bytes_i == '0;
    aborted_nx = 1'b0;
    if (state == IDLE && load) state_nx = ISSUE;
    if (state == ISSUE && free && (bus.abort_i || rem_q == '0)) state_nx = DRAIN;
    if (state == DRAIN && cnt_nx == '0) begin
      state_nx = IDLE;
      done_nx = 1'b1;
      aborted_nx = abort_q || bus.abort_i;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      addr_q <= '0;
      rem_q <= '0;
      fixed_q <= 1'b0;
      abort_q <= 1'b0;
      req_valid <= 1'b0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
      cnt <= '0;
      req_q <= '0;
    end else begin
      cnt <= cnt_nx;
      done_q <= done_nx;
      aborted_q <= aborted_nx;
      abort_q <= !accept && (abort_q || (state != IDLE && bus.abort_i));
      req_valid <= load || (req_valid && !hs);
      if (load) begin
        req_q <= calc_req;
        addr_q <= c_fixed ? c_addr : c_addr + ADDR_WIDTH'(consumed);
        rem_q <= c_rem - consumed;
        fixed_q <= c_fixed;
      end
    end
  assign unused = ^req_q;
  assign bus.desc_ready_o = rst && state == IDLE;
  assign bus.req_valid_o = req_valid;
  assign bus.req_addr_o = req_q.addr[ADDR_WIDTH-1:0];
  assign bus.req_alen_o = req_q.alen;
  assign bus.req_size_o = req_q.size;
  assign bus.req_fixed_o = req_q.fixed;
  assign bus.req_strb_first_o = req_q.strb_first[BPB-1:0];
  assign bus.req_strb_last_o = req_q.strb_last[BPB-1:0];
  assign bus.busy_o = state != IDLE;
  assign bus.done_o = done_q;
  assign bus.aborted_o = aborted_q;
endmodule
